// File: rtl/grid_pkg.sv
// ----------------------------------------------------------------------------
// grid_pkg
//   Definitions shared by the sudoku grid readout path:
//     - readout_state_t : one-hot readout FSM state, same encoding style as
//                         the grid FSM
//     - grid_len/grid_area/grid_dw/grid_pw/grid_aw : geometry derivations
//                         from the block order
//   Configuration macros:
//     GRID_ORD               default block order (3 when not supplied)
//     GRID_READOUT_CKSUM_EN  adds the CKSUM state for the trailing checksum beat
// ----------------------------------------------------------------------------
`ifndef GRID_ORD
`define GRID_ORD 3
`endif

package grid_pkg;

`ifdef GRID_READOUT_CKSUM_EN
    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        STREAM = 3'b010,
        CKSUM  = 3'b100
    } readout_state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'b01,
        STREAM = 2'b10
    } readout_state_t;
`endif

    // Row/column length of the grid.
    function automatic int unsigned grid_len(input int unsigned ord);
        return ord * ord;
    endfunction

    // Number of tiles in the grid.
    function automatic int unsigned grid_area(input int unsigned ord);
        return grid_len(ord) * grid_len(ord);
    endfunction

    // Width of a binary digit index.
    function automatic int unsigned grid_dw(input int unsigned ord);
        return $clog2(grid_len(ord));
    endfunction

    // Width of a beat position; one extra code is reserved for the checksum beat.
    function automatic int unsigned grid_pw(input int unsigned ord);
        return $clog2(grid_area(ord) + 1);
    endfunction

    // Width of the tile index used to address the snapshot.
    function automatic int unsigned grid_aw(input int unsigned ord);
        return $clog2(grid_area(ord));
    endfunction

endpackage

// File: rtl/grid_readout_onehot_enc.sv
// ----------------------------------------------------------------------------
// onehot_enc
//   Purely combinational one-hot to binary encoder with a validity flag.
//   Ports:
//     value  in  N  tile value, expected one-hot
//     digit  out W  index of the lowest set bit (0 when no bit is set)
//     bad    out 1  value is not exactly one-hot
// ----------------------------------------------------------------------------
module onehot_enc #(
    parameter int unsigned N = 9,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] value,
    output logic [W-1:0] digit,
    output logic         bad
);

    always_comb begin
        digit = '0;
        // Scan from the top down so the lowest set bit wins.
        for (int unsigned i = N; i > 0; i--) begin
            if (value[i-1]) begin
                digit = W'(i - 1);
            end
        end
        bad = !$onehot(value);
    end

endmodule

// File: rtl/grid_readout.sv
// ----------------------------------------------------------------------------
// grid_readout
//   Solution dump for the sudoku tile grid. On a request after a successful
//   solve, snapshots every tile's one-hot value and streams the snapshot one
//   cell per beat in row-major order over a valid/ready handshake.
//   Ports:
//     clock, reset   clock; synchronous active-high reset
//     grid_done      grid has reached DONE
//     grid_success   grid is solved
//     values         one-hot tiles, tile (r,c) at [(r*LEN+c)*LEN +: LEN]
//     rq_dump        dump request, sampled every cycle
//     rq_nack        1-cycle pulse when a request is refused
//     busy           high while not IDLE
//     out_valid/out_ready  beat handshake
//     out_digit      binary index of the tile's set bit
//     out_pos        row-major cell index of the beat
//     out_bad        tile was not exactly one-hot
//     out_last       final beat of the dump
//   Configuration:
//     GRID_READOUT_CKSUM_EN  appends a checksum beat (XOR of all digits,
//                            pos = AREA) after the last cell
// ----------------------------------------------------------------------------
`ifndef GRID_ORD
`define GRID_ORD 3
`endif

module grid_readout
    import grid_pkg::*;
#(
    parameter  int unsigned GRID_ORD = `GRID_ORD,
    localparam int unsigned LEN      = grid_len(GRID_ORD),
    localparam int unsigned AREA     = grid_area(GRID_ORD),
    localparam int unsigned DW       = grid_dw(GRID_ORD),
    localparam int unsigned PW       = grid_pw(GRID_ORD)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               grid_done,
    input  logic               grid_success,
    input  logic [AREA*LEN-1:0] values,
    input  logic               rq_dump,
    output logic               rq_nack,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_digit,
    output logic [PW-1:0]      out_pos,
    output logic               out_bad,
    output logic               out_last
);

    localparam int unsigned   AW       = grid_aw(GRID_ORD);
    localparam logic [AW-1:0] LAST_IDX = AW'(AREA - 1);

    readout_state_t state;
    logic [AW-1:0]  idx;
    logic [LEN-1:0] snap [AREA];
    logic [LEN-1:0] tile;
    logic [DW-1:0]  tile_digit;
    logic           tile_bad;
    logic           accept;
    logic           handshake;
`ifdef GRID_READOUT_CKSUM_EN
    logic [DW-1:0]  cksum;
`endif

    assign accept    = (state == IDLE) && rq_dump && grid_done && grid_success;
    assign handshake = out_valid && out_ready;
    assign tile      = snap[idx];

    onehot_enc #(
        .N(LEN),
        .W(DW)
    ) u_enc (
        .value(tile),
        .digit(tile_digit),
        .bad  (tile_bad)
    );

    // Snapshot is deliberately left out of reset; it is only read while streaming.
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int unsigned i = 0; i < AREA; i++) begin
                snap[i] <= values[i*LEN +: LEN];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            rq_nack   <= 1'b0;
`ifdef GRID_READOUT_CKSUM_EN
            cksum     <= '0;
`endif
        end else begin
            rq_nack <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= STREAM;
                        idx       <= '0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
`ifdef GRID_READOUT_CKSUM_EN
                        cksum     <= '0;
`endif
                    end else if (rq_dump) begin
                        rq_nack <= 1'b1;
                    end
                end
                STREAM: begin
                    if (handshake) begin
`ifdef GRID_READOUT_CKSUM_EN
                        cksum <= cksum ^ tile_digit;
`endif
                        if (idx == LAST_IDX) begin
`ifdef GRID_READOUT_CKSUM_EN
                            state <= CKSUM;
`else
                            state     <= IDLE;
                            idx       <= '0;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
`ifdef GRID_READOUT_CKSUM_EN
                CKSUM: begin
                    if (handshake) begin
                        state     <= IDLE;
                        idx       <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    idx       <= '0;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Beat fields are gated by out_valid so they read as zero outside a dump,
    // since the unreset snapshot may hold anything.
    always_comb begin
        out_digit = '0;
        out_pos   = '0;
        out_bad   = 1'b0;
        out_last  = 1'b0;
        if (out_valid) begin
            out_digit = tile_digit;
            out_bad   = tile_bad;
            out_pos   = PW'(idx);
`ifdef GRID_READOUT_CKSUM_EN
            if (state == CKSUM) begin
                out_digit = cksum;
                out_bad   = 1'b0;
                out_pos   = PW'(AREA);
                out_last  = 1'b1;
            end
`else
            out_last = (idx == LAST_IDX);
`endif
        end
    end

endmodule
